// File: rtl/linear_pkg.sv
// +--------------------------------------------------------------------------+
// | linear_pkg : shared types, state encoding and requantisation helpers     |
// | for linear_mac_engine. Optional macro: LINEAR_MAC_ROUND_EN               |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package linear_pkg;

  localparam int PKG_N          = 16;
  localparam int PKG_DATA_WIDTH = 8;
  localparam int ROW_W          = $clog2(PKG_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic signed [PKG_N-1:0][PKG_N-1:0][PKG_DATA_WIDTH-1:0] matrix_t;
  typedef logic signed [PKG_N-1:0][PKG_DATA_WIDTH-1:0]             bias_t;

  // Clamp a wide signed value into the signed range of a dw-bit result.
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v,
                                                   input int                 dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input logic signed [63:0] bias,
                                                 input int                 frac,
                                                 input int                 dw);
    logic signed [63:0] t;
    t = acc;
`ifdef LINEAR_MAC_ROUND_EN
    if (frac > 0)
      t = t + (64'sd1 <<< (frac - 1));
`endif
    t = t >>> frac;
    return sat_to_dw(t + bias, dw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/linear_mac_lane.sv
// +--------------------------------------------------------------------------+
// | linear_mac_lane : one output column's signed multiply-accumulate         |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module linear_mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] w,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_WIDTH'(prod);
  end

endmodule

`default_nettype wire

// File: rtl/linear_mac_engine.sv
// +--------------------------------------------------------------------------+
// | linear_mac_engine : start/done responder computing                       |
// |   out = sat((mat_a x wt) >>> FRAC_BITS + bias), one row per pass.        |
// | Optional macro: LINEAR_MAC_ROUND_EN (round half up before the shift)     |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module linear_mac_engine
  import linear_pkg::*;
#(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int FRAC_BITS   = 0
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     start,
  input  logic signed [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] mat_a,
  input  logic signed [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] wt,
  input  logic signed [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]                  bias,
  output logic signed [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] out_matrix,
  output logic                                                     busy,
  output logic                                                     done
);

  localparam int N     = MATRIX_SIZE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] k;
  logic             start_q;
  logic             lane_clr;
  logic             lane_en;

  logic signed [ACC_WIDTH-1:0]  acc [N];
  logic [N-1:0][DATA_WIDTH-1:0] wb_row;

  // start is captured one cycle in IDLE before the run begins, so the first
  // MAC cycle starts one edge after the controller's sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_q) next_state = MAC;
      MAC:  if (k == LAST) next_state = WB;
      WB:   next_state = (row == LAST) ? DONE : MAC;
      DONE: if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      k       <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= (state == IDLE) && !start_q && start;
      case (state)
        IDLE: begin
          row <= '0;
          k   <= '0;
        end
        MAC: k <= (k == LAST) ? '0 : k + 1'b1;
        WB: begin
          k <= '0;
          if (row != LAST)
            row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lane_clr = (state == IDLE) || (state == WB);
  assign lane_en  = (state == MAC);

  for (genvar j = 0; j < N; j++) begin : g_lane
    linear_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (lane_clr),
      .en  (lane_en),
      .a   ($signed(mat_a[row][k])),
      .w   ($signed(wt[k][j])),
      .acc (acc[j])
    );

    assign wb_row[j] = DATA_WIDTH'(requant(64'(acc[j]), 64'($signed(bias[j])),
                                           FRAC_BITS, DATA_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_matrix <= '0;
    else if (state == WB)
      out_matrix[row] <= wb_row;
  end

  assign busy = (state == MAC) || (state == WB);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_linear_mac_engine.sv
// +--------------------------------------------------------------------------+
// | tb_linear_mac_engine : randomized self-checking bench for                |
// | linear_mac_engine, FRAC_BITS=0 and FRAC_BITS=1 instances in parallel.    |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_linear_mac_engine;

  localparam int N  = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [N-1:0][N-1:0][DW-1:0] mat_a;
  logic signed [N-1:0][N-1:0][DW-1:0] wt;
  logic signed [N-1:0][DW-1:0]        bias;
  logic signed [N-1:0][N-1:0][DW-1:0] out0;
  logic signed [N-1:0][N-1:0][DW-1:0] out1;
  logic busy0, done0, busy1, done1;

  int total = 0;
  int bad   = 0;

  int A [N][N];
  int W [N][N];
  int B [N];
  int snap [N][N];

  always #5 clk = ~clk;

  linear_mac_engine #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(20), .FRAC_BITS(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .mat_a(mat_a), .wt(wt), .bias(bias),
    .out_matrix(out0), .busy(busy0), .done(done0)
  );

  linear_mac_engine #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(20), .FRAC_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mat_a(mat_a), .wt(wt), .bias(bias),
    .out_matrix(out1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer matrix product, floor/round shift, bias, clamp.
  function automatic int ref_out(input int i, input int j, input int frac);
    int acc;
    int v;
    acc = 0;
    for (int kk = 0; kk < N; kk++)
      acc += A[i][kk] * W[kk][j];
`ifdef LINEAR_MAC_ROUND_EN
    if (frac > 0)
      acc += 1 << (frac - 1);
`endif
    v = (acc >>> frac) + B[j];
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int nonzero0();
    int n;
    n = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (out0[i][j] != '0) n++;
    return n;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = A[i][j][DW-1:0];
        wt[i][j]    = W[i][j][DW-1:0];
      end
      bias[i] = B[i][DW-1:0];
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        check({tag, "_f0"}, int'($signed(out0[i][j])), ref_out(i, j, 0));
        check({tag, "_f1"}, int'($signed(out1[i][j])), ref_out(i, j, 1));
      end
  endtask

  // Raise start, count edges to done and busy cycles, then check results.
  task automatic run_pass(input string tag);
    int cyc;
    int busy_n;
    @(negedge clk);
    drive();
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc    = 0;
    busy_n = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (busy0) busy_n++;
      if (done0) begin
        cyc = c;
        break;
      end
    end
    check({tag, "_latency"}, cyc, 273);
    check({tag, "_busy_cycles"}, busy_n, 272);
    check({tag, "_done1"}, int'(done1), 1);
    check_outputs(tag);
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, int'(done0), 0);
    check({tag, "_busy_low"}, int'(busy0), 0);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        W[i][j] = rnd8();
      end
      B[i] = 0;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = rnd8();
        W[i][j] = rnd8();
      end
      B[i] = rnd8();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mat_a = '0;
    wt    = '0;
    bias  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy0), 0);
    check("reset_done", int'(done0), 0);
    check("reset_out_nonzero", nonzero0(), 0);
    @(negedge clk);
    rst = 1'b0;

    // Identity: result equals wt
    set_identity();
    run_pass("identity");
    check("identity_corner", int'($signed(out0[N-1][0])), W[N-1][0]);
    drop_start("identity");

    // Bias only
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = 0;
        W[i][j] = rnd8();
      end
      B[i] = i - 8;
    end
    run_pass("bias");
    drop_start("bias");

    // Saturation high and low
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = 127;
        W[i][j] = 127;
      end
      B[i] = 0;
    end
    run_pass("sat_hi");
    check("sat_hi_elem", int'($signed(out0[3][5])), 127);
    drop_start("sat_hi");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        W[i][j] = -128;
    run_pass("sat_lo");
    check("sat_lo_elem", int'($signed(out0[7][2])), -128);
    drop_start("sat_lo");

    // Random passes; the last one is followed by the handshake test
    set_random();
    run_pass("rand0");
    drop_start("rand0");
    set_random();
    run_pass("rand1");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        snap[i][j] = ref_out(i, j, 0);
    set_random();
    @(negedge clk);
    drive();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_done", int'(done0), 1);
      check("hold_out_r0", int'($signed(out0[0][c])), snap[0][c]);
      check("hold_out_rl", int'($signed(out0[N-1][c])), snap[N-1][c]);
    end
    drop_start("hold");
    run_pass("rerun");
    drop_start("rerun");

    // Asynchronous reset in the middle of a run
    set_identity();
    @(negedge clk);
    drive();
    start = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy0), 0);
    check("midrst_done", int'(done0), 0);
    check("midrst_out_nonzero", nonzero0(), 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_pass("after_rst");
    drop_start("after_rst");

    // Rounding: acc=3 and acc=-3 with FRAC_BITS=1
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = 0;
        W[i][j] = 0;
      end
      B[i] = 0;
    end
    A[0][0] = 3;
    A[1][0] = -3;
    W[0][0] = 1;
    run_pass("round");
`ifdef LINEAR_MAC_ROUND_EN
    check("round_pos", int'($signed(out1[0][0])), 2);
    check("round_neg", int'($signed(out1[1][0])), -1);
`else
    check("round_pos", int'($signed(out1[0][0])), 1);
    check("round_neg", int'($signed(out1[1][0])), -2);
`endif
    check("round_f0_pos", int'($signed(out0[0][0])), 3);
    check("round_f0_neg", int'($signed(out0[1][0])), -3);
    drop_start("round");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
